lzc_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream stream port among `NumIn` requesters. The masked and unmasked request vectors each feed a trailing-zero counter, which selects the winner in O(log N) depth. A registered priority pointer advances past each served requester. The block sits in front of shared resources such as a single FPU/divider issue port or a memory port, and also serves as the generic stream arbiter in common cells.

---
 rtl/lzc_rr_arbiter_pkg.sv | 10 +
 rtl/lzc_rr_arbiter_if.sv | 33 +++
 rtl/lzc_rr_arbiter_lzc.sv | 44 ++++
 rtl/lzc_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_lzc_rr_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/lzc_rr_arbiter_pkg.sv
// Shared helpers for the lzc_rr_arbiter slice.
// Provides idx_width(), which sizes index and counter fields from an item count.
package lzc_rr_arbiter_pkg;

  // Bits needed to index num_idx items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/lzc_rr_arbiter_if.sv
// Stream bundle between NumIn requesters, the arbiter and one downstream port.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment that drives the requests and the downstream ready.
interface lzc_rr_arbiter_if
  import lzc_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) ();

  // upstream side, one lane per requester
  logic [NumIn-1:0]                req_i;
  logic [NumIn-1:0]                gnt_o;
  logic [NumIn-1:0][DataWidth-1:0] data_i;

  // downstream side
  logic                            req_o;
  logic                            gnt_i;
  logic [DataWidth-1:0]            data_o;
  logic [IdxWidth-1:0]             idx_o;

  modport slave (
    input  req_i, data_i, gnt_i,
    output gnt_o, req_o, data_o, idx_o
  );

  modport master (
    output req_i, data_i, gnt_i,
    input  gnt_o, req_o, data_o, idx_o
  );

endinterface

// File: rtl/lzc_rr_arbiter_lzc.sv
// Trailing/leading zero counter built as a binary reduction tree.
// MODE = 0 counts trailing zeros and MODE = 1 counts leading zeros.
// empty_o flags an all-zero input; cnt_o is then meaningless.
module lzc_rr_arbiter_lzc
  import lzc_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter bit          MODE     = 1'b0,
  parameter int unsigned CntWidth = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  localparam int unsigned Pad = 1 << CntWidth;

  logic [Pad-1:0]               node_v;
  logic [Pad-1:0][CntWidth-1:0] node_c;

  // Reduce pairs level by level in place. Node n of a level is built from
  // nodes 2n and 2n+1 of the level below. Writing in ascending n never
  // overwrites an entry that is still waiting to be read. The lower-index
  // child wins, and picking the upper child adds that level's half-span to
  // the count.
  always_comb begin
    node_v = '0;
    node_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      node_v[i] = MODE ? in_i[WIDTH-1-i] : in_i[i];
    end
    for (int unsigned d = 0; d < CntWidth; d++) begin
      for (int unsigned n = 0; n < (Pad >> (d + 1)); n++) begin
        node_c[n] = node_v[2*n] ? node_c[2*n]
                                : (node_c[2*n+1] | CntWidth'(32'd1 << d));
        node_v[n] = node_v[2*n] | node_v[2*n+1];
      end
    end
  end

  assign cnt_o   = node_c[0];
  assign empty_o = ~node_v[0];

endmodule

// File: rtl/lzc_rr_arbiter.sv
// Round-robin stream arbiter: NumIn requesters share one downstream port.
// A registered pointer rr_q gives one index the highest priority. The winner
// is the first request at or above rr_q, wrapping to index 0. Two trailing-zero
// counters find the winner with logarithmic depth. On each handshake the
// pointer advances past the served index, modulo NumIn.
// Optional feature macro: LZC_RR_ARBITER_LOCK_EN. When it is defined, the
// winner is held stable while the downstream port stalls.
module lzc_rr_arbiter
  import lzc_rr_arbiter_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  lzc_rr_arbiter_if.slave bus
);

  if (NumIn == 1) begin : g_single

    // With one requester, the block is a pass-through and has no state.
    assign bus.req_o  = bus.req_i[0];
    assign bus.idx_o  = '0;
    assign bus.data_o = bus.data_i[0];
    assign bus.gnt_o  = bus.req_i & {NumIn{bus.gnt_i}};

    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_ni, flush_i};

  end else begin : g_multi

    logic [NumIn-1:0]     req;
    logic                 any_req;
    logic                 handshake;
    logic [NumIn-1:0]     prio_mask;
    logic [NumIn-1:0]     masked_req;
    logic [IdxWidth-1:0]  masked_cnt;
    logic                 masked_empty;
    logic [IdxWidth-1:0]  req_cnt;
    logic                 req_empty;
    logic [IdxWidth-1:0]  winner;
    logic [IdxWidth-1:0]  sel_idx;
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] data_sel;
    logic [IdxWidth-1:0]  rr_q, rr_d;

    assign req       = bus.req_i;
    assign any_req   = |req;
    assign handshake = any_req & bus.gnt_i;

    // Only indices at or above the pointer take part in the first search.
    always_comb begin
      prio_mask = '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        prio_mask[i] = (IdxWidth'(i) >= rr_q);
      end
    end

    assign masked_req = req & prio_mask;

    lzc_rr_arbiter_lzc #(
      .WIDTH (NumIn),
      .MODE  (1'b0)
    ) i_lzc_masked (
      .in_i    (masked_req),
      .cnt_o   (masked_cnt),
      .empty_o (masked_empty)
    );

    lzc_rr_arbiter_lzc #(
      .WIDTH (NumIn),
      .MODE  (1'b0)
    ) i_lzc_req (
      .in_i    (req),
      .cnt_o   (req_cnt),
      .empty_o (req_empty)
    );

    // If nothing is requesting at or above the pointer, the search wraps to 0.
    assign winner = masked_empty ? req_cnt : masked_cnt;

`ifdef LZC_RR_ARBITER_LOCK_EN
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic                lock_hold;

    // If the locked requester drops out, normal arbitration takes over in the
    // same cycle, so a lane that is not requesting is never granted.
    assign lock_hold = lock_q & req[lock_idx_q];
    assign sel_idx   = lock_hold ? lock_idx_q : winner;

    // Lock on a stalled offer; release on handshake, flush or idle.
    always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (flush_i || handshake) begin
        lock_d = 1'b0;
      end else if (any_req) begin
        lock_d     = 1'b1;
        lock_idx_d = idx;
      end else begin
        lock_d = 1'b0;
      end
    end

    // Lock registers.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
                     lock_q |-> req[lock_idx_q])
      else $error("lzc_rr_arbiter: requester %0d withdrew while stalled", lock_idx_q);
`endif
`else
    assign sel_idx = winner;
`endif

    assign idx      = req_empty ? '0 : sel_idx;
    assign data_sel = bus.data_i[idx];

    assign bus.req_o  = any_req;
    assign bus.idx_o  = idx;
    assign bus.data_o = data_sel;

    // Only the winning lane sees the downstream ready.
    always_comb begin
      bus.gnt_o = '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        bus.gnt_o[i] = handshake & (idx == IdxWidth'(i));
      end
    end

    // Flush overrides advancing; the wrap keeps rr_q below NumIn.
    always_comb begin
      rr_d = rr_q;
      if (flush_i) begin
        rr_d = '0;
      end else if (handshake) begin
        rr_d = (idx == IdxWidth'(NumIn - 1)) ? '0 : idx + IdxWidth'(1);
      end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        rr_q <= '0;
      end else begin
        rr_q <= rr_d;
      end
    end

  end

endmodule

// File: tb/tb_lzc_rr_arbiter.sv
// Scoreboard bench for lzc_rr_arbiter with NumIn = 4.
// Each stimulus cycle pushes its predicted outputs. The reference model
// predicts them by scanning cyclically from the pointer. A monitor on the
// falling edge pops each entry and compares it with the DUT.
module tb_lzc_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  lzc_rr_arbiter_if #(.NumIn(N), .DataWidth(DW)) bus ();

  lzc_rr_arbiter #(
    .NumIn     (N),
    .DataWidth (DW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    string          tag;
    logic           req_o;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  int m_rr;
  bit m_lock;
  int m_lock_idx;

  function automatic int pick(input logic [N-1:0] req);
`ifdef LZC_RR_ARBITER_LOCK_EN
    if (m_lock && req[m_lock_idx]) return m_lock_idx;
`endif
    for (int k = 0; k < N; k++) begin
      if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
  endtask

  task automatic step(input string tag, input logic [N-1:0] req,
                      input logic g, input logic fl, input logic rn);
    exp_t e;
    int   w;
    bus.req_i = req;
    bus.gnt_i = g;
    flush     = fl;
    rst_n     = rn;
    for (int i = 0; i < N; i++) bus.data_i[i] = $urandom();
    w       = pick(req);
    e.tag   = tag;
    e.req_o = (req != '0);
    e.idx   = (w < 0) ? '0 : IW'(w);
    e.data  = bus.data_i[e.idx];
    e.gnt   = (g && w >= 0) ? (N'(1) << w) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!rn || fl) begin
      m_rr   = 0;
      m_lock = 1'b0;
    end else if (w >= 0 && g) begin
      m_rr   = (w + 1) % N;
      m_lock = 1'b0;
    end else if (w >= 0) begin
      m_lock     = 1'b1;
      m_lock_idx = w;
    end else begin
      m_lock = 1'b0;
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, "req_o", 64'(bus.req_o), 64'(e.req_o));
        check(e.tag, "gnt_o", 64'(bus.gnt_o), 64'(e.gnt));
        check(e.tag, "idx_o", 64'(bus.idx_o), 64'(e.idx));
        check(e.tag, "data_o", 64'(bus.data_o), 64'(e.data));
      end else if (bus.req_o !== 1'b0) begin
        check("idle", "req_o", 64'(bus.req_o), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_i  = '0;
    bus.gnt_i  = 1'b0;
    bus.data_i = '0;
    flush      = 1'b0;
    rst_n      = 1'b0;
    m_rr       = 0;
    m_lock     = 1'b0;
    m_lock_idx = 0;
    @(posedge clk);
    #1;

    // reset with requests pending, then idle under reset
    step("rst_req", 4'b1111, 1'b1, 1'b0, 1'b0);
    step("rst_req", 4'b1111, 1'b1, 1'b0, 1'b0);
    step("rst_idle", 4'b0000, 1'b1, 1'b0, 1'b0);
    // first grants after release, then fair rotation
    for (int i = 0; i < 8; i++) step("rotate", 4'b1111, 1'b1, 1'b0, 1'b1);
    // sparse requests
    for (int i = 0; i < 4; i++) step("sparse", 4'b1010, 1'b1, 1'b0, 1'b1);
    // wrap-around after a grant of idx 3
    step("wrap0", 4'b0001, 1'b1, 1'b0, 1'b1);
    step("wrap1", 4'b0011, 1'b1, 1'b0, 1'b1);
    // stall with pointer at 2, then a higher-priority arrival
    step("stall", 4'b0010, 1'b0, 1'b0, 1'b1);
    step("stall_new", 4'b0110, 1'b0, 1'b0, 1'b1);
    step("stall_go", 4'b0110, 1'b1, 1'b0, 1'b1);
    step("stall_rest", 4'b0110, 1'b1, 1'b0, 1'b1);
    // flush mid-stall with pointer at 3
    step("pre_flush", 4'b0100, 1'b1, 1'b0, 1'b1);
    step("flush", 4'b1111, 1'b0, 1'b1, 1'b1);
    step("post_flush", 4'b1111, 1'b0, 1'b0, 1'b1);
    step("post_flush", 4'b1111, 1'b1, 1'b0, 1'b1);
    // reset during a stall
    step("rst_stall", 4'b1110, 1'b0, 1'b0, 1'b1);
    step("rst_stall", 4'b1110, 1'b0, 1'b0, 1'b0);
    step("after_rst", 4'b1110, 1'b1, 1'b0, 1'b1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("random", N'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) != 0));
    end

    bus.req_i = '0;
    bus.gnt_i = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("end", "sb_left", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
